// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle unsigned restoring divider with start/done handshake
module seq_divider32 #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [n-1:0] Dividend,
  input  logic [n-1:0] Divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Quotient,
  output logic [n-1:0] Remainder,
  output logic         divByZero
);
  localparam int CW = $clog2(n);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t         r_state;
  logic [n-1:0]   r_rem, r_q, r_div, r_quo, r_remo;
  logic [CW-1:0]  r_cnt;
  logic           r_busy, r_done, r_dbz;
  logic [n:0]     w_sh, w_trial;
  logic [n-1:0]   w_rn, w_qn;
  logic           w_accept;
  // restored remainder is always below the divisor, so its extra top bit is never needed between steps
  assign w_sh     = {r_rem, r_q[n-1]};
  assign w_trial  = w_sh + ~{1'b0, r_div} + {{n{1'b0}}, 1'b1};
  assign w_rn     = w_trial[n] ? w_sh[n-1:0] : w_trial[n-1:0];
  assign w_qn     = {r_q[n-2:0], ~w_trial[n]};
  assign w_accept = start && r_state != RUN;
  assign busy      = r_busy;
  assign done      = r_done;
  assign Quotient  = r_quo;
  assign Remainder = r_remo;
  assign divByZero = r_dbz;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_div <= Divisor;
      r_rem <= '0;
      r_q   <= Dividend;
      r_cnt <= '0;
      if (Divisor == '0) begin
        r_state <= FINISH;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_quo   <= '1;
        r_remo  <= Dividend;
        r_dbz   <= 1'b1;
      end else begin
        r_state <= RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rn;
      r_q   <= w_qn;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(n - 1)) begin
        r_state <= FINISH;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_quo   <= w_qn;
        r_remo  <= w_rn;
        r_dbz   <= 1'b0;
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: directed vector table plus corner sequences and random pairs for seq_divider32
module tb_seq_divider32;
  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] Dividend = '0, Divisor = '0;
  logic        busy, done, divByZero;
  logic [31:0] Quotient, Remainder;
  int          tests = 0, fails = 0;
  logic [31:0] pq = '0, pr = '0;
  logic        pz = 1'b0;

  seq_divider32 dut (
    .clk(clk), .nReset(nReset), .start(start), .Dividend(Dividend), .Divisor(Divisor),
    .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        z;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at a negedge with the DUT in IDLE or FINISH; returns at the negedge where done is seen
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int gl,
                    output int k, output int bc, output logic held);
    held = 1'b1; bc = 0; k = 0;
    Dividend = a; Divisor = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (busy) bc++;
      if (!done && (Quotient !== pq || Remainder !== pr || divByZero !== pz)) held = 1'b0;
      if (k == gl) begin
        Dividend = 32'd9; Divisor = 32'd9; start = 1'b1;
      end else start = 1'b0;
    end while (!done && k < 100);
  endtask

  task automatic run_chk(input string name, input logic [31:0] a, input logic [31:0] b, input int gl);
    int k, bc;
    logic held;
    logic [31:0] eq, er;
    logic ez;
    ez = (b == 0);
    eq = ez ? 32'hFFFFFFFF : a / b;
    er = ez ? a : a % b;
    op(a, b, gl, k, bc, held);
    chk({name, " latency"}, 64'(k), ez ? 64'd1 : 64'd33);
    chk({name, " busy cycles"}, 64'(bc), ez ? 64'd0 : 64'd32);
    chk({name, " held"}, 64'(held), 64'd1);
    chk({name, " Q"}, 64'(Quotient), 64'(eq));
    chk({name, " R"}, 64'(Remainder), 64'(er));
    chk({name, " dbz"}, 64'(divByZero), 64'(ez));
    pq = eq; pr = er; pz = ez;
  endtask

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, " done drop"}, 64'(done), 64'd0);
    chk({name, " busy idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    v[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,   z: 1'b0};
    v[1]  = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,   z: 1'b0};
    v[2]  = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,   z: 1'b0};
    v[3]  = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,   z: 1'b0};
    v[4]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,   z: 1'b0};
    v[5]  = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd5,   z: 1'b1};
    v[6]  = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd0,   z: 1'b1};
    v[7]  = '{a: 32'd1000,       b: 32'd3,          q: 32'd333,        r: 32'd1,   z: 1'b0};
    v[8]  = '{a: 32'd50,         b: 32'd6,          q: 32'd8,          r: 32'd2,   z: 1'b0};
    v[9]  = '{a: 32'd81,         b: 32'd9,          q: 32'd9,          r: 32'd0,   z: 1'b0};
    v[10] = '{a: 32'd12345678,   b: 32'd1000,       q: 32'd12345,      r: 32'd678, z: 1'b0};
    v[11] = '{a: 32'h80000000,   b: 32'd2,          q: 32'h40000000,   r: 32'd0,   z: 1'b0};
    v[12] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,   z: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset Q", 64'(Quotient), 64'd0);
    chk("reset R", 64'(Remainder), 64'd0);
    chk("reset dbz", 64'(divByZero), 64'd0);
    nReset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      int k, bc;
      logic held;
      op(v[i].a, v[i].b, 0, k, bc, held);
      chk($sformatf("vec%0d latency", i), 64'(k), v[i].z ? 64'd1 : 64'd33);
      chk($sformatf("vec%0d busy cycles", i), 64'(bc), v[i].z ? 64'd0 : 64'd32);
      chk($sformatf("vec%0d held", i), 64'(held), 64'd1);
      chk($sformatf("vec%0d Q", i), 64'(Quotient), 64'(v[i].q));
      chk($sformatf("vec%0d R", i), 64'(Remainder), 64'(v[i].r));
      chk($sformatf("vec%0d dbz", i), 64'(divByZero), 64'(v[i].z));
      pq = v[i].q; pr = v[i].r; pz = v[i].z;
      idle_chk($sformatf("vec%0d", i));
    end

    run_chk("ignored start", 32'd1000, 32'd3, 10);
    idle_chk("ignored start");

    Dividend = 32'd1000; Divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 nReset = 1'b0;
    #1;
    chk("async busy", 64'(busy), 64'd0);
    chk("async done", 64'(done), 64'd0);
    chk("async Q", 64'(Quotient), 64'd0);
    chk("async R", 64'(Remainder), 64'd0);
    chk("async dbz", 64'(divByZero), 64'd0);
    @(negedge clk);
    nReset = 1'b1;
    pq = '0; pr = '0; pz = 1'b0;
    @(negedge clk);
    chk("aborted no done", 64'(done), 64'd0);
    run_chk("after reset 50/6", 32'd50, 32'd6, 0);
    idle_chk("after reset");

    run_chk("b2b first 100/7", 32'd100, 32'd7, 0);
    Dividend = 32'd81; Divisor = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b no idle", 64'(busy), 64'd1);
    begin
      int k = 1;
      while (!done && k < 100) begin @(negedge clk); k++; end
      chk("b2b latency", 64'(k), 64'd33);
      chk("b2b Q", 64'(Quotient), 64'd9);
      chk("b2b R", 64'(Remainder), 64'd0);
    end
    pq = 32'd9; pr = 32'd0; pz = 1'b0;
    idle_chk("b2b");

    run_chk("dbz first", 32'd5, 32'd0, 0);
    run_chk("dbz reenter", 32'd7, 32'd0, 0);
    idle_chk("dbz reenter");

    for (int i = 0; i < 1000; i++) begin
      int k, bc;
      logic held;
      logic [63:0] prod;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) b = '0;
      op(a, b, 0, k, bc, held);
      if (b != 0) begin
        prod = 64'(Quotient) * 64'(b) + 64'(Remainder);
        chk($sformatf("rand%0d invariant", i), prod, 64'(a));
        chk($sformatf("rand%0d R<D", i), 64'(Remainder < b), 64'd1);
        chk($sformatf("rand%0d Q", i), 64'(Quotient), 64'(a / b));
      end else begin
        chk($sformatf("rand%0d dbz Q", i), 64'(Quotient), 64'hFFFFFFFF);
        chk($sformatf("rand%0d dbz R", i), 64'(Remainder), 64'(a));
      end
      chk($sformatf("rand%0d dbz", i), 64'(divByZero), 64'(b == 0));
      chk($sformatf("rand%0d latency", i), 64'(k), (b == 0) ? 64'd1 : 64'd33);
      pq = (b == 0) ? 32'hFFFFFFFF : a / b;
      pr = (b == 0) ? a : a % b;
      pz = (b == 0);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
